// File: rtl/seg_scan_display.sv
// seg_scan_display: multiplexed 7-segment driver for cascaded counter digits.
// Frame-coherent snapshot, leading-zero blanking, anti-ghost gap, sticky overflow.
module seg_scan_display #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500,
  parameter bit HEX_EN    = 1'b1,
  parameter bit LZB_EN    = 1'b1,
  parameter bit SEG_AL    = 1'b1,
  parameter bit DIG_AL    = 1'b1
) (
  input  logic                  clk_50M,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   din,
  input  logic                  co_in,
  input  logic                  hold,
  input  logic                  ovf_clr,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_done,
  output logic                  ovf
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLK     = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  localparam logic [7:0]        SEG_OFF = SEG_AL ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] DIG_OFF = DIG_AL ? {DIGITS{1'b1}}
                                                 : {DIGITS{1'b0}};

  logic [CW-1:0]            cnt;
  logic [IW-1:0]            idx;
  logic [4*DIGITS-1:0]      din_r;
  logic [DIGITS-1:0][3:0]   shadow;
  logic                     co_q;

  logic                     slot_end;
  logic                     frame_end;
  logic                     seen;
  logic [DIGITS-1:0]        lzb;
  logic [3:0]               cur;
  logic [7:0]               seg_nx;
  logic [DIGITS-1:0]        dig_nx;

  function automatic logic [6:0] dec7(input logic [3:0] v);
    logic [6:0] p;
    unique case (v)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      4'hF: p = 7'h71;
    endcase
    if (!HEX_EN && v > 4'h9)
      p = 7'h40;
    return p;
  endfunction

  assign slot_end   = (cnt == CNT_MAX);
  assign frame_end  = slot_end && (idx == IDX_MAX);
  assign frame_done = frame_end;

  // Blank digit k only while every digit from k up to the top is zero.
  always_comb begin
    lzb  = '0;
    seen = 1'b0;
    for (int k = DIGITS - 1; k > 0; k--) begin
      seen   = seen | (shadow[k] != 4'h0);
      lzb[k] = LZB_EN & ~seen;
    end
  end

  assign cur = shadow[idx];

  always_comb begin
    seg_nx = 8'h00;
    dig_nx = '0;
    if (cnt >= BLK) begin
      dig_nx = DIGITS'(1) << idx;
      seg_nx = {ovf, lzb[idx] ? 7'h00 : dec7(cur)};
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= '0;
      din_r <= '0;
      co_q  <= 1'b0;
    end else begin
      din_r <= din;
      co_q  <= co_in;
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // hold is only looked at on the frame boundary so a frame never tears.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n)
      shadow <= '0;
    else if (frame_end && !hold)
      shadow <= din_r;
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n)
      ovf <= 1'b0;
    else if (co_in && !co_q)
      ovf <= 1'b1;
    else if (ovf_clr)
      ovf <= 1'b0;
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      seg     <= SEG_OFF;
      dig_sel <= DIG_OFF;
    end else begin
      seg     <= SEG_AL ? ~seg_nx : seg_nx;
      dig_sel <= DIG_AL ? ~dig_nx : dig_nx;
    end
  end

endmodule
